bus_arb_mux: RTL and testbench
==============================

Name: bus_arb_mux

Overview:
Parametrised N-master shared-memory bus arbiter and datapath mux for the single SRAM data port. It generalises the fixed two-master (CPU/DMAC) arbitration and steering to NUM_M masters. It adds round-robin fairness, a bounded tenure with forced hand-off, and release-gated writes. It sits between the masters (CPU, DMAC channels) and the SRAM data port.

Parameters:
NUM_M, 2, number of bus masters (>=2); master 0 = CPU by convention
ADDR_W, 8, address width
DATA_W, 8, data width
MAX_HOLD, 16, max consecutive granted cycles while another master waits; 0 = unlimited tenure
OWN_W, $clog2(NUM_M), width of owner index

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
m_breq  input  NUM_M  per-master bus request, level, held for whole transfer sequence
m_addr  input  NUM_M*ADDR_W  master i address at bits [i*ADDR_W +: ADDR_W]
m_wdata  input  NUM_M*DATA_W  master i write data, same packing
m_we  input  NUM_M  per-master write enable
m_bgrt  output  NUM_M  one-hot (or zero) registered grant
m_rdata  output  DATA_W  SRAM read data broadcast; 0 when no grant
s_addr  output  ADDR_W  SRAM address
s_wdata  output  DATA_W  SRAM write data
s_we  output  1  SRAM write enable
s_rdata  input  DATA_W  SRAM read data
owner  output  OWN_W  index of current grantee (valid when busy)
busy  output  1  high when any grant is active

Behaviour:
- Reset (rst=0, asynchronous): m_bgrt=0, busy=0, owner=0, hold_cnt=0, last pointer=NUM_M-1 (master 0 gets first priority). Combinational outputs follow: s_we=0, s_addr=0, s_wdata=0, m_rdata=0.
- States: IDLE (no grant) and OWNED (exactly one m_bgrt bit high). Grant is registered.
- IDLE: at an edge with any m_breq set, grant the first requester scanning last+1, last+2, ... modulo NUM_M. Then owner=winner, last=winner, hold_cnt=0, go to OWNED. Grant latency is 1 cycle after request first sampled.
- OWNED, owner's m_breq=1:
  - If MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another master requests, hand off at this edge to the next requester in rotation after owner. The new grant becomes visible next cycle, with no idle gap and hold_cnt=0.
  - Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1, so a lone master keeps the bus indefinitely.
- OWNED, owner's m_breq=0 (release): at that edge, grant the next requester in rotation after owner (direct switch, hold_cnt=0). If there is none, go to IDLE with m_bgrt=0.
- Grant never goes to a master whose m_breq is low at the deciding edge. At most one m_bgrt bit is high at any time.
- Datapath, combinational from owner:
  - s_addr = m_addr[owner] and s_wdata = m_wdata[owner] when busy, else 0.
  - s_we = busy & m_breq[owner] & m_we[owner]. A write in the release cycle is suppressed.
  - m_rdata = s_rdata when busy, else 0. Masters qualify m_rdata with their own m_bgrt bit.
- Simultaneous request and release: the releasing master is lowest priority in the scan and regains the bus only if it is the sole requester at a later edge.
- Reset mid-transfer drops the grant immediately; any in-flight SRAM write in that cycle is lost (s_we=0).
- NUM_M non-power-of-2: rotation wraps at NUM_M-1 to 0; owner never takes values >= NUM_M.

Test Plan:
1. Reset release, m_breq=2'b01 at cycle 0 -> m_bgrt=2'b01 at cycle 1; owner=0; busy=1; s_addr=m_addr[0]; no s_we before the grant.
2. NUM_M=2, both request from the same edge after reset -> master 0 granted first. Master 0 drops breq after 3 cycles -> m_bgrt goes 01->10 with no zero cycle. Master 1 then holds -> keeps grant; s_addr tracks m_addr[1].
3. MAX_HOLD=4, master 0 holds breq continuously, master 1 requests -> master 0 granted exactly 4 cycles, then master 1. With master 1 held and master 0 still requesting -> return to master 0 after 4 more cycles. Alternation continues.
4. NUM_M=3, all request, each releases after 1 granted cycle then re-requests -> grant order 0,1,2,0,1,2. Owner wraps correctly.
5. Master 0 granted, m_we=1, drops m_breq with m_we still 1 -> s_we=0 in that cycle; SRAM content at that address unchanged.
6. Assert rst low mid-grant, asynchronous to clk -> m_bgrt=0, s_we=0 immediately. After release, master 0 again has first priority.

Source files
------------

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N-master round-robin arbiter and datapath mux for the single
// SRAM data port. A registered one-hot grant selects which master's address,
// write data and write enable reach the SRAM. A bounded tenure forces a
// hand-off when another master waits. Writes are gated by the owner's live
// request, so a write in the release cycle never reaches the SRAM.
module bus_arb_mux #(
  parameter int NUM_M    = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16,
  parameter int OWN_W    = $clog2(NUM_M)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_breq,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M-1:0]          m_we,
  output logic [NUM_M-1:0]          m_bgrt,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic                      s_we,
  input  logic [DATA_W-1:0]         s_rdata,
  output logic [OWN_W-1:0]          owner,
  output logic                      busy
);

  // Tenure counter only needs to reach MAX_HOLD-1; MAX_HOLD of 0 or 1 keeps it at 0.
  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;

  // One extra bit so that base + offset never overflows before the wrap.
  localparam int               CNT_W     = OWN_W + 1;
  localparam logic [CNT_W-1:0] NUM_M_EXT = CNT_W'(NUM_M);
  localparam logic [OWN_W-1:0] LAST_RST  = OWN_W'(NUM_M - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_q,  last_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;

  logic [NUM_M-1:0]   req_mask;
  logic [OWN_W-1:0]   base;
  logic [CNT_W-1:0]   pos;
  logic [OWN_W-1:0]   cand;
  logic [OWN_W-1:0]   winner;
  logic               found;

  // Round-robin scan: first requester after base, the owner itself excluded while it holds the bus.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    req_mask = m_breq;
    if (state_q == OWNED) req_mask[owner_q] = 1'b0;
    base   = (state_q == OWNED) ? owner_q : last_q;
    pos    = '0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      pos = {1'b0, base} + CNT_W'(i);
      if (pos >= NUM_M_EXT) pos = pos - NUM_M_EXT;
      cand = pos[OWN_W-1:0];
      if (!found && req_mask[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic: idle grant, release hand-over, forced hand-off and tenure counting.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = OWNED;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          last_d          = winner;
          hold_d          = '0;
        end
      end
      OWNED: begin
        if (!m_breq[owner_q] || (MAX_HOLD != 0 && hold_q == HOLD_LAST && found)) begin
          if (found) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            owner_d         = winner;
            last_d          = winner;
            hold_d          = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbitration state register; reset gives master 0 first priority.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign m_bgrt = grant_q;
  assign owner  = owner_q;
  assign busy   = (state_q == OWNED);

  // SRAM steering from the registered owner; everything is zero while idle.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_we    = 1'b0;
    m_rdata = '0;
    if (busy) begin
      s_addr  = m_addr[int'(owner_q) * ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(owner_q) * DATA_W +: DATA_W];
      s_we    = m_breq[owner_q] & m_we[owner_q];
      m_rdata = s_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb_bus_arb_mux: directed bench for a 3-master, MAX_HOLD=4 arbiter with a
// behavioural SRAM. A cycle-by-cycle vector table covers reset, idle grant,
// release hand-over, tenure hand-off and three-way rotation. Hand-written
// sequences cover the release-cycle write, asynchronous reset and address
// tracking.
module tb_bus_arb_mux;

  localparam int NUM_M  = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int OWN_W  = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_M-1:0]         m_breq;
  logic [NUM_M-1:0]         m_we;
  logic [ADDR_W-1:0]        addr  [NUM_M];
  logic [DATA_W-1:0]        wdata [NUM_M];
  logic [NUM_M*ADDR_W-1:0]  m_addr;
  logic [NUM_M*DATA_W-1:0]  m_wdata;
  logic [NUM_M-1:0]         m_bgrt;
  logic [DATA_W-1:0]        m_rdata;
  logic [ADDR_W-1:0]        s_addr;
  logic [DATA_W-1:0]        s_wdata;
  logic                     s_we;
  logic [DATA_W-1:0]        s_rdata;
  logic [OWN_W-1:0]         owner;
  logic                     busy;

  logic [DATA_W-1:0]        mem [256];

  int checks = 0;
  int errors = 0;

  assign m_addr  = {addr[2], addr[1], addr[0]};
  assign m_wdata = {wdata[2], wdata[1], wdata[0]};

  bus_arb_mux #(
    .NUM_M    (NUM_M),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_breq  (m_breq),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_we    (m_we),
    .m_bgrt  (m_bgrt),
    .m_rdata (m_rdata),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_we    (s_we),
    .s_rdata (s_rdata),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous-write, asynchronous-read SRAM.
  always @(posedge clk) if (s_we) mem[s_addr] <= s_wdata;
  assign s_rdata = mem[s_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             rst_n;
    logic [NUM_M-1:0] breq;
    logic [NUM_M-1:0] we;
    logic             busy;
    logic [OWN_W-1:0] owner;
    logic             swe;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic [2:0] b, input logic [2:0] w,
                              input logic bz, input logic [1:0] o, input logic sw);
    vec_t v;
    v.rst_n = r; v.breq = b; v.we = w; v.busy = bz; v.owner = o; v.swe = sw;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_M-1:0]  exp_grant;
    logic [ADDR_W-1:0] exp_addr;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    addr[0]  = 8'h10; addr[1]  = 8'h21; addr[2]  = 8'h32;
    wdata[0] = 8'hD0; wdata[1] = 8'hD1; wdata[2] = 8'hD2;
    rst = 1'b0; m_breq = '0; m_we = '0;

    // {rst_n, breq, we, exp busy, exp owner, exp s_we}, state after each edge
    // Reset, single request grant, release to idle
    tv.push_back(mk(0, 3'b000, 3'b111, 0, 0, 0));
    tv.push_back(mk(1, 3'b001, 3'b000, 1, 0, 0));
    tv.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0));
    // Both request after reset: 0 first, release hands directly to 1, 1 keeps bus alone
    tv.push_back(mk(0, 3'b011, 3'b001, 0, 0, 0));
    tv.push_back(mk(1, 3'b011, 3'b001, 1, 0, 1));
    tv.push_back(mk(1, 3'b011, 3'b001, 1, 0, 1));
    tv.push_back(mk(1, 3'b011, 3'b001, 1, 0, 1));
    tv.push_back(mk(1, 3'b010, 3'b001, 1, 1, 0));
    for (int i = 0; i < 5; i++) tv.push_back(mk(1, 3'b010, 3'b001, 1, 1, 0));
    // Tenure limit 4: 0,0,0,0 then 1,1,1,1 then back to 0
    tv.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0));
    tv.push_back(mk(1, 3'b001, 3'b000, 1, 0, 0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1, 3'b011, 3'b000, 1, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1, 3'b011, 3'b000, 1, 1, 0));
    for (int i = 0; i < 2; i++) tv.push_back(mk(1, 3'b011, 3'b000, 1, 0, 0));
    // Three-way rotation with release and re-request: 0,1,2,0,1,2,0
    tv.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0));
    tv.push_back(mk(1, 3'b111, 3'b000, 1, 0, 0));
    tv.push_back(mk(1, 3'b110, 3'b000, 1, 1, 0));
    tv.push_back(mk(1, 3'b101, 3'b000, 1, 2, 0));
    tv.push_back(mk(1, 3'b011, 3'b000, 1, 0, 0));
    tv.push_back(mk(1, 3'b110, 3'b000, 1, 1, 0));
    tv.push_back(mk(1, 3'b101, 3'b000, 1, 2, 0));
    tv.push_back(mk(1, 3'b011, 3'b000, 1, 0, 0));

    foreach (tv[i]) begin
      rst    = tv[i].rst_n;
      m_breq = tv[i].breq;
      m_we   = tv[i].we;
      @(posedge clk);
      @(negedge clk);
      exp_grant = tv[i].busy ? (NUM_M'(1) << tv[i].owner) : '0;
      exp_addr  = tv[i].busy ? addr[tv[i].owner] : '0;
      check($sformatf("v%0d_grant", i), 32'(m_bgrt), 32'(exp_grant));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("v%0d_swe", i), 32'(s_we), 32'(tv[i].swe));
      check($sformatf("v%0d_saddr", i), 32'(s_addr), 32'(exp_addr));
      check($sformatf("v%0d_swdata", i), 32'(s_wdata),
            32'(tv[i].busy ? wdata[tv[i].owner] : 8'h00));
      check($sformatf("v%0d_rdata", i), 32'(m_rdata),
            32'(tv[i].busy ? mem[exp_addr] : 8'h00));
      if (tv[i].busy || !tv[i].rst_n)
        check($sformatf("v%0d_owner", i), 32'(owner), 32'(tv[i].owner));
    end

    // Release-cycle write is suppressed
    rst = 1'b0; m_breq = '0; m_we = '0;
    @(negedge clk);
    rst = 1'b1;
    wdata[0] = 8'hA5; m_breq = 3'b001; m_we = 3'b001;
    #1 check("wr_pre_grant_swe", 32'(s_we), 32'd0);
    @(posedge clk); @(negedge clk);
    check("wr_grant", 32'(m_bgrt), 32'b001);
    check("wr_swe", 32'(s_we), 32'd1);
    @(posedge clk); @(negedge clk);
    check("wr_mem", 32'(mem[8'h10]), 32'hA5);
    check("wr_rdata", 32'(m_rdata), 32'hA5);
    wdata[0] = 8'h3C; m_breq = 3'b000;
    #1 check("rel_swe", 32'(s_we), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rel_mem", 32'(mem[8'h10]), 32'hA5);
    check("rel_grant", 32'(m_bgrt), 32'd0);
    check("rel_rdata", 32'(m_rdata), 32'd0);
    m_we = '0; wdata[0] = 8'hD0;

    // Asynchronous reset mid-grant, then master 0 has first priority again
    m_breq = 3'b001;
    @(posedge clk); @(negedge clk);
    check("ar_grant", 32'(m_bgrt), 32'b001);
    m_we = 3'b001;
    #3 rst = 1'b0;
    #1;
    check("ar_grant_drop", 32'(m_bgrt), 32'd0);
    check("ar_swe", 32'(s_we), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1; m_breq = 3'b011; m_we = '0;
    @(posedge clk); @(negedge clk);
    check("ar_first_prio", 32'(m_bgrt), 32'b001);

    // Hand over to master 1 and follow its address changes
    m_breq = 3'b010;
    @(posedge clk); @(negedge clk);
    check("trk_grant", 32'(m_bgrt), 32'b010);
    check("trk_owner", 32'(owner), 32'd1);
    addr[1] = 8'h77;
    #1 check("trk_saddr", 32'(s_addr), 32'h77);
    addr[1] = 8'h21;
    #1 check("trk_saddr2", 32'(s_addr), 32'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
